div_iter_d32: RTL

Iterative 32-bit integer divider for the execute stage. Produces quotient and remainder for signed or unsigned operands with a start/busy/done handshake. Both results are registered and held stable so they can drive two data inputs of the 8-way 32-bit writeback result-select mux directly. The mux select for those inputs is chosen only while `done` is high.

---
 rtl/div_iter_d32.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_iter_d32.sv
// Iterative 32-bit signed/unsigned divider, one restoring step per cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, op_signed      request a division; operand mode (sampled with start)
//   dividend, divisor     operands (sampled with start)
//   flush                 synchronous abort, returns to IDLE
//   busy, done            busy in CALC/FIX; one-cycle done pulse in DONE
//   quotient, remainder   registered results, held until the next DONE
module div_iter_d32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic           sgn_q, sgn_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   dmag, vmag;
  logic [W:0]     trial;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    dmag  = (op_signed && dividend[W-1]) ? W'(-dividend) : dividend;
    vmag  = (op_signed && divisor[W-1])  ? W'(-divisor)  : divisor;
    // Upper 33 bits of the shifted register minus divisor; bit W is the borrow
    trial = acc_q[2*W-1:W-1] - {1'b0, dvs_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          sgn_d  = op_signed;
          negq_d = dividend[W-1] ^ divisor[W-1];
          negr_d = dividend[W-1];
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else if (op_signed && dividend == 32'h8000_0000 && divisor == '1) begin
            quo_d   = 32'h8000_0000;
            rem_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = {{W{1'b0}}, dmag};
            dvs_d   = vmag;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (trial[W]) acc_d = {acc_q[2*W-2:0], 1'b0};
        else          acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = (sgn_q && negq_q) ? W'(-acc_q[W-1:0])   : acc_q[W-1:0];
        rem_d   = (sgn_q && negr_q) ? W'(-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort keeps the previously published results
    if (flush) begin
      state_d = S_IDLE;
      quo_d   = quo_q;
      rem_d   = rem_q;
    end

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
